reg_bank_ops: RTL and testbench

REG_BANK_OPS -- requirements
Module: reg_bank_ops

---
 rtl/reg_bank_ops.sv | 132 +++++++++++++
 tb/tb_reg_bank_ops.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_ops.sv
// Register bank with per-register arithmetic write operations, a registered
// one-cycle read port, per-register zero flags, and sticky wrap and
// address-error flags.
module reg_bank_ops #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [1:0]          wr_op,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [WIDTH-1:0]    rd_data,
  output logic                rd_valid,
  output logic [NUM_REGS-1:0] zero_flags,
  output logic                ovf,
  input  logic                ovf_clr,
  output logic                addr_err
);

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_INC   = 2'b01,
    OP_DEC   = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  // One extra bit so NUM_REGS itself is representable when it equals 2^ADDR_W.
  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  logic [WIDTH-1:0] regs [NUM_REGS];

  logic             wr_ok;
  logic             rd_ok;
  logic             wr_commit;
  logic [WIDTH-1:0] wr_cur;
  logic [WIDTH-1:0] wr_next;
  logic             wr_wrap;

  // Addresses at or beyond NUM_REGS do not map to a register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NUM_REGS_W);
  endfunction

  // Increment with the carry-out in the MSB; carry set means all-ones wrapped to 0.
  function automatic logic [WIDTH:0] inc_wrap(input logic [WIDTH-1:0] v);
    return {1'b0, v} + {{WIDTH{1'b0}}, 1'b1};
  endfunction

  // Decrement with the borrow in the MSB; borrow set means 0 wrapped to all-ones.
  function automatic logic [WIDTH:0] dec_wrap(input logic [WIDTH-1:0] v);
    return {1'b0, v} - {{WIDTH{1'b0}}, 1'b1};
  endfunction

  // Decode the write operation into the new register value and its wrap status.
  always_comb begin
    logic [WIDTH:0] ext;
    wr_ok     = addr_ok(wr_addr);
    rd_ok     = addr_ok(rd_addr);
    wr_commit = wr_en & wr_ok;
    wr_cur    = wr_ok ? regs[wr_addr] : '0;
    wr_next   = wr_cur;
    wr_wrap   = 1'b0;
    ext       = '0;
    case (op_t'(wr_op))
      OP_LOAD:  wr_next = wr_data;
      OP_INC: begin
        ext     = inc_wrap(wr_cur);
        wr_next = ext[WIDTH-1:0];
        wr_wrap = ext[WIDTH];
      end
      OP_DEC: begin
        ext     = dec_wrap(wr_cur);
        wr_next = ext[WIDTH-1:0];
        wr_wrap = ext[WIDTH];
      end
      OP_CLEAR: wr_next = '0;
      default:  wr_next = wr_cur;
    endcase
  end

  // Register file: only the addressed in-range register is written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_commit) begin
      regs[wr_addr] <= wr_next;
    end
  end

  // Read port stage: samples the pre-write contents, so a same-cycle write is not visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_ok ? regs[rd_addr] : '0;
    end
  end

  // Sticky wrap flag: a wrap in the same cycle as ovf_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (wr_commit && wr_wrap) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  // Sticky address error from either port; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_err <= 1'b0;
    end else if ((wr_en && !wr_ok) || (rd_en && !rd_ok)) begin
      addr_err <= 1'b1;
    end
  end

  // Zero flags follow the current register contents directly.
  always_comb begin
    zero_flags = '0;
    for (int i = 0; i < NUM_REGS; i++) zero_flags[i] = (regs[i] == '0);
  end

endmodule

// File: tb/tb_reg_bank_ops.sv
// Scoreboard bench for reg_bank_ops: two builds (16-bit x 8 regs and
// 8-bit x 6 regs) share the same stimulus; a behavioural model per build
// predicts register contents, flags and read results.
module tb_reg_bank_ops;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset   = 1'b0;
  logic        wr_en   = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [1:0]  wr_op   = '0;
  logic [15:0] wr_data = '0;
  logic        rd_en   = 1'b0;
  logic [2:0]  rd_addr = '0;
  logic        ovf_clr = 1'b0;

  logic [15:0] rd_data_a;
  logic        rd_valid_a;
  logic [7:0]  zf_a;
  logic        ovf_a;
  logic        err_a;
  logic [7:0]  rd_data_b;
  logic        rd_valid_b;
  logic [5:0]  zf_b;
  logic        ovf_b;
  logic        err_b;

  reg_bank_ops #(.WIDTH(16), .NUM_REGS(8), .ADDR_W(3)) u_a (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_op(wr_op),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .zero_flags(zf_a), .ovf(ovf_a), .ovf_clr(ovf_clr),
    .addr_err(err_a)
  );

  reg_bank_ops #(.WIDTH(8), .NUM_REGS(6), .ADDR_W(3)) u_b (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_op(wr_op),
    .wr_data(wr_data[7:0]), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .zero_flags(zf_b), .ovf(ovf_b), .ovf_clr(ovf_clr),
    .addr_err(err_b)
  );

  // Reference model state, one slot per build.
  int unsigned mregs [2][8];
  int unsigned mmask [2] = '{32'hFFFF, 32'hFF};
  int unsigned mnum  [2] = '{8, 6};
  bit          movf  [2];
  bit          merr  [2];
  int unsigned hold  [2];
  int unsigned q0 [$];
  int unsigned q1 [$];

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  task automatic chk(input string name, input int d, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%h expected=%h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Apply the current inputs to the model of build d (pre-edge state -> post-edge state).
  task automatic model_step(input int d);
    int unsigned v;
    int unsigned wa;
    bit wrap;
    if (reset) begin
      for (int i = 0; i < 8; i++) mregs[d][i] = 0;
      movf[d] = 0;
      merr[d] = 0;
      hold[d] = 0;
      return;
    end
    if (rd_en) begin
      v = (int'(rd_addr) < mnum[d]) ? mregs[d][rd_addr] : 0;
      if (d == 0) q0.push_back(v); else q1.push_back(v);
      hold[d] = v;
      if (int'(rd_addr) >= mnum[d]) merr[d] = 1;
    end
    wrap = 0;
    if (wr_en) begin
      wa = wr_addr;
      if (wa >= mnum[d]) begin
        merr[d] = 1;
      end else begin
        case (wr_op)
          2'd0: mregs[d][wa] = wr_data & mmask[d];
          2'd1: begin
            if (mregs[d][wa] == mmask[d]) wrap = 1;
            mregs[d][wa] = (mregs[d][wa] + 1) & mmask[d];
          end
          2'd2: begin
            if (mregs[d][wa] == 0) wrap = 1;
            mregs[d][wa] = (mregs[d][wa] + mmask[d]) & mmask[d];
          end
          default: mregs[d][wa] = 0;
        endcase
      end
    end
    if (wrap) movf[d] = 1;
    else if (ovf_clr) movf[d] = 0;
  endtask

  task automatic cyc(input bit rst, input bit we, input logic [2:0] wa, input logic [1:0] op,
                     input logic [15:0] wd, input bit re, input logic [2:0] ra, input bit oc);
    @(negedge clk);
    #2;
    reset = rst; wr_en = we; wr_addr = wa; wr_op = op; wr_data = wd;
    rd_en = re; rd_addr = ra; ovf_clr = oc;
    model_step(0);
    model_step(1);
    mon_on = 1'b1;
  endtask

  task automatic idle();
    cyc(0, 0, 3'd0, 2'd0, 16'h0, 0, 3'd0, 0);
  endtask

  // Monitor: after each active edge compare the outputs of both builds with the model.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mon_on) begin
        for (int d = 0; d < 2; d++) begin
          int unsigned act_rd;
          bit          act_rv;
          int unsigned act_zf;
          int unsigned exp_zf;
          int unsigned exp_rd;
          act_rd = (d == 0) ? rd_data_a : {8'h0, rd_data_b};
          act_rv = (d == 0) ? rd_valid_a : rd_valid_b;
          act_zf = (d == 0) ? zf_a : {2'b0, zf_b};
          exp_zf = 0;
          for (int i = 0; i < 8; i++)
            if (i < int'(mnum[d]) && mregs[d][i] == 0) exp_zf |= (1 << i);
          if (act_rv) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
              checks++;
              errors++;
              $display("FAIL rd_valid_unexpected dut%0d actual=1 expected=0 at %0t", d, $time);
            end else begin
              exp_rd = (d == 0) ? q0.pop_front() : q1.pop_front();
              chk("rd_data", d, act_rd, exp_rd);
            end
          end else begin
            chk("rd_valid_missing", d, (d == 0) ? q0.size() : q1.size(), 0);
            chk("rd_data_hold", d, act_rd, hold[d]);
          end
          chk("zero_flags", d, act_zf, exp_zf);
          chk("ovf", d, (d == 0) ? ovf_a : ovf_b, movf[d]);
          chk("addr_err", d, (d == 0) ? err_a : err_b, merr[d]);
        end
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic with occasional resets.
  initial begin
    logic [15:0] wd;
    cyc(1, 0, 3'd0, 2'd0, 16'h0, 0, 3'd0, 0);
    cyc(1, 0, 3'd0, 2'd0, 16'h0, 1, 3'd0, 0);
    idle();
    // Load then read back r2.
    cyc(0, 1, 3'd2, 2'd0, 16'h1234, 0, 3'd0, 0);
    cyc(0, 0, 3'd0, 2'd0, 16'h0, 1, 3'd2, 0);
    idle();
    // Wrap on INC, then DEC with simultaneous ovf_clr keeps ovf set.
    cyc(0, 1, 3'd5, 2'd0, 16'hFFFF, 0, 3'd0, 0);
    cyc(0, 1, 3'd5, 2'd1, 16'h0, 0, 3'd0, 0);
    cyc(0, 1, 3'd5, 2'd2, 16'h0, 1, 3'd5, 1);
    cyc(0, 0, 3'd0, 2'd0, 16'h0, 1, 3'd5, 1);
    idle();
    // Read-old on same-cycle read/write of r1.
    cyc(0, 1, 3'd1, 2'd0, 16'h0005, 0, 3'd0, 0);
    cyc(0, 1, 3'd1, 2'd0, 16'h00AA, 1, 3'd1, 0);
    cyc(0, 0, 3'd0, 2'd0, 16'h0, 1, 3'd1, 0);
    // 8-bit wrap in both directions on r0, ovf_clr in between.
    cyc(0, 1, 3'd0, 2'd0, 16'h00FF, 0, 3'd0, 0);
    cyc(0, 1, 3'd0, 2'd1, 16'h0, 0, 3'd0, 0);
    cyc(0, 0, 3'd0, 2'd0, 16'h0, 0, 3'd0, 1);
    cyc(0, 1, 3'd0, 2'd2, 16'h0, 1, 3'd0, 0);
    cyc(0, 1, 3'd3, 2'd3, 16'h0, 1, 3'd0, 0);
    // Out-of-range write and read (out of range only for the 6-register build).
    cyc(0, 1, 3'd7, 2'd0, 16'h4321, 0, 3'd0, 0);
    cyc(0, 0, 3'd0, 2'd0, 16'h0, 1, 3'd6, 0);
    idle();
    // Reset with simultaneous write and read after nonzero loads.
    cyc(0, 1, 3'd4, 2'd0, 16'h0F0F, 0, 3'd0, 0);
    cyc(0, 1, 3'd2, 2'd1, 16'h0, 0, 3'd0, 0);
    cyc(1, 1, 3'd0, 2'd0, 16'h5555, 1, 3'd3, 1);
    idle();
    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: wd = 16'h0000;
        1: wd = 16'hFFFF;
        2: wd = 16'h00FF;
        default: wd = 16'($urandom);
      endcase
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
          2'($urandom_range(0, 3)), wd, ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)),
          ($urandom_range(0, 7) == 0));
    end
    idle();
    idle();
    @(negedge clk);
    #3;
    chk("queue_drain_a", 0, q0.size(), 0);
    chk("queue_drain_b", 1, q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
